cpu_reg_responder: RTL and testbench
====================================

// Module: cpu_reg_responder
// PURPOSE
// - Target side of the CPU write/read bus: decodes the CPU address, holds a bank of 8-bit registers, and answers each access with a one-cycle ready pulse after programmable wait states.
// - Sits behind the address decoder as the slave the CPU bus-functional model talks to. Out-of-range accesses are flagged or silently absorbed.
// PARAMETERS
// - ADDR_W      8     address bus width
// - DATA_W      8     data bus width
// - NUM_REGS    8     registers in bank; legal range 1..2**ADDR_W
// - BASE_ADDR   0     address of register 0
// - WAIT_CYCLES 1     wait states between request capture and ready; 0..15
// - RESET_VAL   8'h00 reset contents of every register
// PORTS
// - clk    in   1       rising-edge clock
// - rst    in   1       asynchronous reset, active-high
// - sel    in   1       CPU request; held high until ready
// - wr_en  in   1       1=write, 0=read; qualified by sel
// - addr   in   ADDR_W  byte address
// - wdata  in   DATA_W  write data
// - rdata  out  DATA_W  read data; valid in ready cycle, held until next read completes
// - ready  out  1       one-cycle completion pulse
// - err    out  1       decode error, valid with ready (see CONFIGURATION)
// BEHAVIOUR
// - Reset (async, any state): FSM->IDLE; ready=0, err=0, rdata=0, all regs=RESET_VAL; wait counter=0.
// - FSM states: IDLE, WAIT, RESP.
//   IDLE: sel=1 at edge -> capture addr/wr_en/wdata, decode hit; go WAIT (WAIT_CYCLES>0) else RESP.
//   WAIT: count down WAIT_CYCLES edges -> RESP. sel drop here aborts: back to IDLE, no write, no ready.
//   RESP: ready=1 for exactly one cycle; write commits at the edge leaving RESP; -> IDLE.
// - Latency: sel sampled at edge N -> ready high in cycle N+1+WAIT_CYCLES.
// - Back-to-back: sel still high in the cycle after ready starts a new access (min 1 idle cycle between pulses).
// - Captured fields rule: addr/wdata/wr_en changes after capture are ignored.
// - Decode: hit = (addr >= BASE_ADDR) && (addr - BASE_ADDR < NUM_REGS); index = addr - BASE_ADDR, width clog2(NUM_REGS); compare done ADDR_W+1 wide, no wrap-around of BASE_ADDR+NUM_REGS.
// - Read hit: rdata <= reg[index], loaded on the edge entering RESP.
// - Read miss: rdata <= 0. Write miss: no register changes.
// - Write then read of the same address returns the new value (write completes before next capture).
// - Reset asserted mid-access: no partial write, ready never pulses for that access.
// CONFIGURATION
// - DEC_ERR_RESP_EN defined: err=1 alongside ready for any miss; err=0 for hits; err=0 outside ready.
// - DEC_ERR_RESP_EN undefined: err tied 0; misses complete normally (ready pulses, read data 0, write dropped).
// TESTING
// - Reset check: assert rst mid-WAIT -> ready/err/rdata=0 immediately, regs 0..7 read back 8'h00.
// - Write/read 0..7: write 8'hA5+i to addr i, read back -> rdata==8'hA5+i, err=0, ready width 1 cycle.
// - Out of range: write 8'h3C to addr 8 and 9, read -> rdata=8'h00; err=1 with DEC_ERR_RESP_EN, 0 without; regs 0..7 unchanged.
// - Latency: WAIT_CYCLES=0 and 3, sel at edge N -> ready in cycle N+1 / N+4 respectively.
// - Abort: raise sel for write 8'hFF to addr 2, drop sel during WAIT -> no ready; addr 2 still holds old value.
// - Back-to-back + stable capture: hold sel, change addr after capture -> first access uses captured addr; second starts the cycle after ready.

Source files
------------

// File: rtl/cpu_reg_responder.sv
// CPU bus target: decodes the address into a bank of registers and answers each access with a
// one-cycle ready pulse after WAIT_CYCLES wait states. Define DEC_ERR_RESP_EN to flag misses on err.
module cpu_reg_responder #(
    parameter int                ADDR_W      = 8,
    parameter int                DATA_W      = 8,
    parameter int                NUM_REGS    = 8,
    parameter int                BASE_ADDR   = 0,
    parameter int                WAIT_CYCLES = 1,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              err
);

    localparam int              IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W:0] BASE_EXT = (ADDR_W + 1)'(BASE_ADDR);
    localparam logic [ADDR_W:0] NUM_EXT  = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [3:0]      WAIT_LD  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [DATA_W-1:0] regs [NUM_REGS];

    logic              cap_wr;
    logic              cap_hit;
    logic [IDX_W-1:0]  cap_idx;
    logic [DATA_W-1:0] cap_wdata;

    // Decode is one bit wider than the address so BASE_ADDR + NUM_REGS never wraps.
    logic [ADDR_W:0]   offset;
    logic              live_hit;
    logic [IDX_W-1:0]  live_idx;

    assign offset   = {1'b0, addr} - BASE_EXT;
    assign live_hit = ({1'b0, addr} >= BASE_EXT) && (offset < NUM_EXT);
    assign live_idx = offset[IDX_W-1:0];

    // With zero wait states RESP is entered on the capture edge, so the live decode is used.
    logic              resp_hit;
    logic              resp_wr;
    logic [IDX_W-1:0]  resp_idx;

    always_comb begin
        resp_hit = cap_hit;
        resp_wr  = cap_wr;
        resp_idx = cap_idx;
        if (state == S_IDLE) begin
            resp_hit = live_hit;
            resp_wr  = wr_en;
            resp_idx = live_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            ready     <= 1'b0;
            rdata     <= '0;
            cap_wr    <= 1'b0;
            cap_hit   <= 1'b0;
            cap_idx   <= '0;
            cap_wdata <= '0;
`ifdef DEC_ERR_RESP_EN
            err       <= 1'b0;
`endif
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    ready <= 1'b0;
                    if (sel) begin
                        cap_wr    <= wr_en;
                        cap_wdata <= wdata;
                        cap_hit   <= live_hit;
                        cap_idx   <= live_idx;
                        if (WAIT_CYCLES == 0) begin
                            state <= S_RESP;
                            ready <= 1'b1;
                            if (!resp_wr) begin
                                rdata <= resp_hit ? regs[resp_idx] : '0;
                            end
`ifdef DEC_ERR_RESP_EN
                            err   <= ~resp_hit;
`endif
                        end else begin
                            cnt   <= WAIT_LD;
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // Dropping sel while waiting abandons the access without a write or a pulse.
                    if (!sel) begin
                        state <= S_IDLE;
                    end else if (cnt == 4'd1) begin
                        state <= S_RESP;
                        ready <= 1'b1;
                        if (!resp_wr) begin
                            rdata <= resp_hit ? regs[resp_idx] : '0;
                        end
`ifdef DEC_ERR_RESP_EN
                        err   <= ~resp_hit;
`endif
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    ready <= 1'b0;
`ifdef DEC_ERR_RESP_EN
                    err   <= 1'b0;
`endif
                    if (cap_wr && cap_hit) begin
                        regs[cap_idx] <= cap_wdata;
                    end
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b0;
                end
            endcase
        end
    end

`ifndef DEC_ERR_RESP_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_reg_responder.sv
// Scoreboard bench for cpu_reg_responder: a 3-wait-state instance and a zero-wait-state instance,
// directed accesses push expected responses, a negedge monitor pops and compares on every ready.
module tb_cpu_reg_responder;

    localparam int W0 = 3;
    localparam int W1 = 0;
`ifdef DEC_ERR_RESP_EN
    localparam bit MISS_ERR = 1'b1;
`else
    localparam bit MISS_ERR = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       sel   [2];
    logic       wr_en [2];
    logic [7:0] addr  [2];
    logic [7:0] wdata [2];
    logic [7:0] rdata [2];
    logic       ready [2];
    logic       err   [2];

    // {dut id, check rdata, expected err, expected rdata}
    logic [10:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          prev_ready [2];

    cpu_reg_responder #(.WAIT_CYCLES(W0)) u_dut0 (
        .clk(clk), .rst(rst), .sel(sel[0]), .wr_en(wr_en[0]), .addr(addr[0]),
        .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]), .err(err[0])
    );

    cpu_reg_responder #(.WAIT_CYCLES(W1)) u_dut1 (
        .clk(clk), .rst(rst), .sel(sel[1]), .wr_en(wr_en[1]), .addr(addr[1]),
        .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]), .err(err[1])
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ready[d] && prev_ready[d]) begin
                checks++;
                errors++;
                $display("FAIL ready_width dut%0d: ready high on two consecutive cycles, required 1", d);
            end
            if (ready[d]) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready dut%0d: ready=1 with no access outstanding", d);
                end else begin
                    logic [10:0] e;
                    e = exp_q.pop_front();
                    checks++;
                    if (32'(e[10]) != d) begin
                        errors++;
                        $display("FAIL resp_dut: ready from dut%0d, required dut%0d", d, e[10]);
                    end
                    checks++;
                    if (err[d] !== e[8]) begin
                        errors++;
                        $display("FAIL resp_err dut%0d: err=%b required %b", d, err[d], e[8]);
                    end
                    if (e[9]) begin
                        checks++;
                        if (rdata[d] !== e[7:0]) begin
                            errors++;
                            $display("FAIL resp_rdata dut%0d: rdata=%02h required %02h", d, rdata[d], e[7:0]);
                        end
                    end
                end
            end else if (err[d] !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL err_outside_ready dut%0d: err=%b required 0", d, err[d]);
            end
            prev_ready[d] = ready[d];
        end
    end

    // driver tasks
    function automatic int wait_of(input int d);
        return (d == 0) ? W0 : W1;
    endfunction

    task automatic access(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                          input logic [7:0] exp_rd, input bit miss, input bit hold, input bit chained);
        int lat;
        if (!chained) @(negedge clk);
        sel[d]   = 1'b1;
        wr_en[d] = wr;
        addr[d]  = a;
        wdata[d] = wd;
        exp_q.push_back({d[0], ~wr, (miss ? MISS_ERR : 1'b0), exp_rd});
        if (chained) @(posedge clk);
        @(posedge clk);
        #1;
        wr_en[d] = ~wr;
        addr[d]  = ~a;
        wdata[d] = ~wd;
        lat = 0;
        @(negedge clk);
        while (!ready[d] && lat < 40) begin
            lat++;
            @(negedge clk);
        end
        checks++;
        if (!ready[d]) begin
            errors++;
            $display("FAIL timeout dut%0d addr %02h: no ready within %0d cycles", d, a, lat);
        end else if (lat != wait_of(d)) begin
            errors++;
            $display("FAIL latency dut%0d addr %02h: %0d cycles after capture, required %0d",
                     d, a, lat, wait_of(d));
        end
        if (!hold) sel[d] = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (ready[d] !== 1'b0 || err[d] !== 1'b0 || rdata[d] !== 8'h00) begin
                errors++;
                $display("FAIL %s dut%0d: ready=%b err=%b rdata=%02h required 0/0/00",
                         tag, d, ready[d], err[d], rdata[d]);
            end
        end
    endtask

    initial begin
        int n_ready;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            sel[d] = 1'b0; wr_en[d] = 1'b0; addr[d] = 8'h00; wdata[d] = 8'h00;
        end
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_state");
        rst = 1'b0;

        // write/read every register
        for (int i = 0; i < 8; i++) access(0, 1'b1, 8'(i), 8'hA5 + 8'(i), 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) access(0, 1'b0, 8'(i), 8'h00, 8'hA5 + 8'(i), 1'b0, 1'b0, 1'b0);

        // out of range
        access(0, 1'b1, 8'h08, 8'h3C, 8'h00, 1'b1, 1'b0, 1'b0);
        access(0, 1'b1, 8'h09, 8'h3C, 8'h00, 1'b1, 1'b0, 1'b0);
        access(0, 1'b0, 8'h08, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        access(0, 1'b0, 8'h03, 8'h00, 8'hA8, 1'b0, 1'b0, 1'b0);
        access(0, 1'b0, 8'h09, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        access(0, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) access(0, 1'b0, 8'(i), 8'h00, 8'hA5 + 8'(i), 1'b0, 1'b0, 1'b0);

        // zero wait states
        access(1, 1'b1, 8'h04, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0);
        access(1, 1'b0, 8'h04, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0);
        access(1, 1'b0, 8'h0C, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        access(1, 1'b0, 8'h04, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0);

        // abort during wait states
        @(negedge clk);
        sel[0] = 1'b1; wr_en[0] = 1'b1; addr[0] = 8'h02; wdata[0] = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        sel[0] = 1'b0;
        n_ready = 0;
        repeat (8) begin
            @(negedge clk);
            if (ready[0]) n_ready++;
        end
        checks++;
        if (n_ready != 0) begin
            errors++;
            $display("FAIL abort_ready: %0d ready pulses after abort, required 0", n_ready);
        end
        access(0, 1'b0, 8'h02, 8'h00, 8'hA7, 1'b0, 1'b0, 1'b0);

        // back-to-back with sel held, fields changed after capture
        access(0, 1'b1, 8'h05, 8'h11, 8'h00, 1'b0, 1'b1, 1'b0);
        access(0, 1'b0, 8'h05, 8'h00, 8'h11, 1'b0, 1'b1, 1'b1);
        access(0, 1'b0, 8'h06, 8'h00, 8'hAB, 1'b0, 1'b0, 1'b1);
        access(1, 1'b1, 8'h01, 8'h22, 8'h00, 1'b0, 1'b1, 1'b0);
        access(1, 1'b0, 8'h01, 8'h00, 8'h22, 1'b0, 1'b0, 1'b1);

        // reset in the middle of a write's wait states
        @(negedge clk);
        sel[0] = 1'b1; wr_en[0] = 1'b1; addr[0] = 8'h03; wdata[0] = 8'h77;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle_outputs("reset_mid_wait");
        sel[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) access(0, 1'b0, 8'(i), 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        access(1, 1'b0, 8'h04, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected responses never seen, required 0", exp_q.size());
        end

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
